manchester_frame_receiver: RTL and testbench

Parametrised Manchester line receiver. It recovers bit timing from a raw asynchronous line, hunts for a configurable preamble, then assembles a fixed-length frame. The frame is presented on a wide output with a one-cycle valid strobe. It is the next-generation front end for the thermostat frame decode path, replacing separate edge-detect, clock-recovery and serial-decode blocks, and adds timing-tolerance checking, timeout and error reporting.

---
 rtl/manchester_frame_receiver.sv | 215 +++++++++++++++++++++
 tb/tb_manchester_frame_receiver.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_frame_receiver.sv
// Manchester line receiver: bit timing recovery, preamble hunt, frame assembly.
// Optional MANCHESTER_RX_CHECKSUM_EN: last payload byte is a mod-256 sum check.
// Ports: clk, rst_n (async low), ena, rx_in (async line) ->
//   frame_data[F], frame_valid, frame_error, busy, bit_strobe, bit_value.
module manchester_frame_receiver #(
  parameter int CLKS_PER_HALF_BIT = 8,
  parameter int TOLERANCE = 2,
  parameter int PREAMBLE_BITS = 8,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE = 8'hAA,
  parameter int FRAME_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  rx_in,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic                  busy,
  output logic                  bit_strobe,
  output logic                  bit_value
);

  localparam int H  = CLKS_PER_HALF_BIT;
  localparam int T  = TOLERANCE;
  localparam int P  = PREAMBLE_BITS;
  localparam int F  = FRAME_BITS;
  localparam int CW = $clog2(2*H+T+2);
  localparam int BW = $clog2(F+1);

  localparam logic [CW-1:0] MAX_C   = CW'(2*H+T+1);
  localparam logic [CW-1:0] SHORT_L = CW'(H-T);
  localparam logic [CW-1:0] SHORT_H = CW'(H+T);
  localparam logic [CW-1:0] LONG_L  = CW'(2*H-T);
  localparam logic [CW-1:0] LONG_H  = CW'(2*H+T);
  localparam logic [BW-1:0] LAST_B  = BW'(F-1);

  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, hist_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mid_q, mid_d, mid_n;
  logic [P-1:0]    pre_q, pre_d;
  logic [F-1:0]    stage_q, stage_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [F-1:0]    frame_data_q, frame_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_error_q, frame_error_d;
  logic            bit_strobe_q, bit_strobe_d;
  logic            bit_value_q, bit_value_d;
`ifdef MANCHESTER_RX_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  logic         edge_det, is_short, is_long, timeout;
  logic [F-1:0] shifted;

  assign edge_det = sync2_q ^ hist_q;
  assign is_short = (cnt_q >= SHORT_L) && (cnt_q <= SHORT_H);
  assign is_long  = (cnt_q >= LONG_L) && (cnt_q <= LONG_H);
  assign timeout  = (cnt_q == MAX_C);
  assign shifted  = {stage_q[F-2:0], sync2_q};

  always_comb begin
    state_d       = state_q;
    cnt_d         = timeout ? cnt_q : cnt_q + 1'b1;
    mid_d         = mid_q;
    mid_n         = mid_q;
    pre_d         = pre_q;
    stage_d       = stage_q;
    bcnt_d        = bcnt_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    bit_strobe_d  = 1'b0;
    bit_value_d   = 1'b0;
`ifdef MANCHESTER_RX_CHECKSUM_EN
    sum_d         = sum_q;
`endif
    // The edge cycle is the first cycle of the new interval, so the
    // count seen at the next edge equals the interval length.
    if (edge_det) cnt_d = CW'(1);
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
      mid_d   = 1'b0;
      pre_d   = '0;
      bcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_d      = SYNC;
            mid_d        = 1'b1;
            pre_d        = '0;
            pre_d[0]     = sync2_q;
            bcnt_d       = '0;
            bit_strobe_d = 1'b1;
            bit_value_d  = sync2_q;
          end
        end
        SYNC: begin
          if (edge_det) begin
            if (is_short || is_long) begin
              mid_n = is_long | ~mid_q;
              mid_d = mid_n;
              if (mid_n) begin
                bit_strobe_d = 1'b1;
                bit_value_d  = sync2_q;
                pre_d        = pre_q << 1;
                pre_d[0]     = sync2_q;
              end
            end else begin
              state_d = IDLE;
            end
          end else if (timeout) begin
            state_d = IDLE;
          end else if (pre_q == PREAMBLE) begin
            state_d = DATA;
            bcnt_d  = '0;
`ifdef MANCHESTER_RX_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
        DATA: begin
          if (edge_det) begin
            if (is_short || is_long) begin
              mid_n = is_long | ~mid_q;
              mid_d = mid_n;
              if (mid_n) begin
                bit_strobe_d = 1'b1;
                bit_value_d  = sync2_q;
                stage_d      = shifted;
                bcnt_d       = bcnt_q + 1'b1;
                if (bcnt_q == LAST_B) begin
                  state_d = IDLE;
`ifdef MANCHESTER_RX_CHECKSUM_EN
                  if (shifted[7:0] == sum_q) begin
                    frame_data_d  = shifted;
                    frame_valid_d = 1'b1;
                  end else begin
                    frame_error_d = 1'b1;
                  end
                end else if (bcnt_q[2:0] == 3'b111) begin
                  sum_d = sum_q + shifted[7:0];
`else
                  frame_data_d  = shifted;
                  frame_valid_d = 1'b1;
`endif
                end
              end
            end else begin
              frame_error_d = 1'b1;
              state_d       = IDLE;
            end
          end else if (timeout) begin
            frame_error_d = 1'b1;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      hist_q        <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      mid_q         <= 1'b0;
      pre_q         <= '0;
      stage_q       <= '0;
      bcnt_q        <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      bit_strobe_q  <= 1'b0;
      bit_value_q   <= 1'b0;
`ifdef MANCHESTER_RX_CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      sync1_q       <= rx_in;
      sync2_q       <= sync1_q;
      hist_q        <= sync2_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mid_q         <= mid_d;
      pre_q         <= pre_d;
      stage_q       <= stage_d;
      bcnt_q        <= bcnt_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      bit_strobe_q  <= bit_strobe_d;
      bit_value_q   <= bit_value_d;
`ifdef MANCHESTER_RX_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != IDLE);
  assign bit_strobe  = bit_strobe_q;
  assign bit_value   = bit_value_q;

endmodule

// File: tb/tb_manchester_frame_receiver.sv
// Self-checking bench for manchester_frame_receiver (H=8, T=2, P=8).
// Frames are scoreboarded; F=24 with the checksum macro, else F=16.
module tb_manchester_frame_receiver;

  localparam int H  = 8;
  localparam int T  = 2;
  localparam int PB = 8;
`ifdef MANCHESTER_RX_CHECKSUM_EN
  localparam int FB = 24;
`else
  localparam int FB = 16;
`endif
  localparam int MAXC = 2*H+T+1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          rx = 1'b0;
  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_error, busy, bit_strobe, bit_value;

  manchester_frame_receiver #(
    .CLKS_PER_HALF_BIT(H),
    .TOLERANCE(T),
    .PREAMBLE_BITS(PB),
    .PREAMBLE(8'hAA),
    .FRAME_BITS(FB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rx_in(rx),
    .frame_data(frame_data),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .busy(busy),
    .bit_strobe(bit_strobe),
    .bit_value(bit_value)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int tog_cyc = 0;

  int            cyc = 0;
  int            n_strobe = 0;
  int            n_valid = 0;
  int            n_err = 0;
  int            err_cyc = 0;
  logic [63:0]   bits_seen = '0;
  logic [FB-1:0] obs_q[$];
  logic [FB-1:0] exp_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bit_strobe) begin
      n_strobe  <= n_strobe + 1;
      bits_seen <= {bits_seen[62:0], bit_value};
    end
    if (frame_valid) begin
      n_valid <= n_valid + 1;
      obs_q.push_back(frame_data);
    end
    if (frame_error) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
  end

  // Drives preamble+payload as Manchester; nbits limits payload bits sent.
  // dlt is added to every edge interval, dd only to the edge at half-bit dpos.
  task automatic send(input logic [PB-1:0] pre, input logic [FB-1:0] pay,
                      input int dlt, input int dpos, input int dd,
                      input int nbits);
    logic [PB+FB-1:0] all;
    logic lvl, hv;
    int last;
    all  = {pre, pay};
    lvl  = rx;
    last = -1;
    for (int h = 0; h < 2*(PB+nbits); h++) begin
      hv = all[PB+FB-1-h/2] ^ (h % 2 == 0);
      if (hv != lvl) begin
        if (last < 0) repeat (2) @(posedge clk);
        else repeat ((h-last)*H + dlt + ((h == dpos) ? dd : 0)) @(posedge clk);
        #2 rx = hv;
        lvl = hv;
        last = h;
        tog_cyc = cyc;
      end
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic settle();
    repeat (MAXC+4) @(posedge clk);
    if (rx) begin
      #2 rx = 1'b0;
      repeat (MAXC+6) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b0;
    ena = 1'b1;
    #1;
    tests += 6;
    if (frame_data !== '0) begin
      fails++; $display("FAIL reset_data: got %h want 0", frame_data);
    end
    if (frame_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b want 0", frame_valid);
    end
    if (frame_error !== 1'b0) begin
      fails++; $display("FAIL reset_error: got %b want 0", frame_error);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    if (bit_strobe !== 1'b0) begin
      fails++; $display("FAIL reset_strobe: got %b want 0", bit_strobe);
    end
    if (bit_value !== 1'b0) begin
      fails++; $display("FAIL reset_value: got %b want 0", bit_value);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

`ifndef MANCHESTER_RX_CHECKSUM_EN
  task automatic test_ideal();
    int s0, v0, e0;
    logic [FB-1:0] got, want;
    logic [PB+FB-1:0] wbits, gbits;
    s0 = n_strobe; v0 = n_valid; e0 = n_err;
    exp_q.push_back(16'h1234);
    send(8'hAA, 16'h1234, 0, -1, 0, FB);
    repeat (2) @(posedge clk);
    tests += 6;
    if (n_strobe - s0 != PB+FB) begin
      fails++; $display("FAIL ideal_strobes: got %0d want %0d", n_strobe-s0, PB+FB);
    end
    if (n_valid - v0 != 1) begin
      fails++; $display("FAIL ideal_valid: got %0d want 1", n_valid-v0);
    end
    if (n_err - e0 != 0) begin
      fails++; $display("FAIL ideal_error: got %0d want 0", n_err-e0);
    end
    wbits = {8'hAA, 16'h1234};
    gbits = bits_seen[PB+FB-1:0];
    if (gbits !== wbits) begin
      fails++; $display("FAIL ideal_bits: got %h want %h", gbits, wbits);
    end
    if (obs_q.size() == 0) begin
      fails++; $display("FAIL ideal_frame: got none want %h", exp_q[0]);
      exp_q.delete();
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        fails++; $display("FAIL ideal_frame: got %h want %h", got, want);
      end
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL ideal_busy: got %b want 0", busy);
    end
    settle();
  endtask

  task automatic test_tolerance();
    int v0, e0;
    int d[2];
    logic [FB-1:0] got, want;
    d[0] = 2; d[1] = -2;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(16'h1234);
      send(8'hAA, 16'h1234, d[k], -1, 0, FB);
      repeat (2) @(posedge clk);
      tests++;
      if (obs_q.size() == 0) begin
        fails++; $display("FAIL tol_frame%0d: got none want 1234", k);
        exp_q.delete();
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin
          fails++; $display("FAIL tol_frame%0d: got %h want %h", k, got, want);
        end
      end
      settle();
    end
    v0 = n_valid; e0 = n_err;
    send(8'hAA, 16'hCAFE, 0, 2*(PB+FB-1)+1, 3, FB);
    repeat (2) @(posedge clk);
    tests += 3;
    if (n_err - e0 != 1) begin
      fails++; $display("FAIL tol_err: got %0d want 1", n_err-e0);
    end
    if (n_valid - v0 != 0) begin
      fails++; $display("FAIL tol_novalid: got %0d want 0", n_valid-v0);
    end
    if (frame_data !== 16'h1234) begin
      fails++; $display("FAIL tol_hold: got %h want 1234", frame_data);
    end
    settle();
  endtask

  task automatic test_preamble_mismatch();
    int s0, v0, e0;
    s0 = n_strobe; v0 = n_valid; e0 = n_err;
    send(8'hAB, 16'h1234, 0, -1, 0, FB);
    repeat (MAXC) @(posedge clk);
    #1;
    tests += 4;
    if (n_strobe - s0 != PB+FB) begin
      fails++; $display("FAIL pre_strobes: got %0d want %0d", n_strobe-s0, PB+FB);
    end
    if (n_valid - v0 != 0) begin
      fails++; $display("FAIL pre_valid: got %0d want 0", n_valid-v0);
    end
    if (n_err - e0 != 0) begin
      fails++; $display("FAIL pre_error: got %0d want 0", n_err-e0);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL pre_busy: got %b want 0", busy);
    end
    settle();
  endtask

  task automatic test_timeout();
    int v0, e0, dt;
    v0 = n_valid; e0 = n_err;
    send(8'hAA, 16'h1234, 0, -1, 0, 5);
    repeat (26) @(posedge clk);
    #1;
    dt = err_cyc - tog_cyc;
    tests += 5;
    if (n_err - e0 != 1) begin
      fails++; $display("FAIL to_err: got %0d want 1", n_err-e0);
    end
    if (dt < 20 || dt > 24) begin
      fails++; $display("FAIL to_time: got %0d want 20..24", dt);
    end
    if (n_valid - v0 != 0) begin
      fails++; $display("FAIL to_valid: got %0d want 0", n_valid-v0);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL to_busy: got %b want 0", busy);
    end
    if (frame_data !== 16'h1234) begin
      fails++; $display("FAIL to_hold: got %h want 1234", frame_data);
    end
    settle();
  endtask

  task automatic test_reset_midframe();
    logic [FB-1:0] got, want;
    send(8'hAA, 16'h1234, 0, -1, 0, 6);
    rst_n = 1'b0;
    #1;
    tests += 4;
    if (frame_data !== '0) begin
      fails++; $display("FAIL rst_data: got %h want 0", frame_data);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    if ({frame_valid, frame_error} !== 2'b00) begin
      fails++; $display("FAIL rst_pulses: got %b want 00", {frame_valid, frame_error});
    end
    if ({bit_strobe, bit_value} !== 2'b00) begin
      fails++; $display("FAIL rst_bit: got %b want 00", {bit_strobe, bit_value});
    end
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (MAXC) @(posedge clk);
    exp_q.push_back(16'hBEEF);
    send(8'hAA, 16'hBEEF, 0, -1, 0, FB);
    repeat (2) @(posedge clk);
    tests += 2;
    if (obs_q.size() == 0) begin
      fails++; $display("FAIL rst_frame: got none want beef");
      exp_q.delete();
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        fails++; $display("FAIL rst_frame: got %h want %h", got, want);
      end
    end
    if (frame_data !== 16'hBEEF) begin
      fails++; $display("FAIL rst_data2: got %h want beef", frame_data);
    end
    settle();
  endtask

  task automatic test_ena();
    int e0, v0;
    e0 = n_err; v0 = n_valid;
    send(8'hAA, 16'h1234, 0, -1, 0, 6);
    tests += 5;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL ena_busy_pre: got %b want 1", busy);
    end
    ena = 1'b0;
    @(posedge clk);
    #1;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL ena_busy: got %b want 0", busy);
    end
    repeat (MAXC+4) @(posedge clk);
    if (n_err - e0 != 0) begin
      fails++; $display("FAIL ena_err: got %0d want 0", n_err-e0);
    end
    if (n_valid - v0 != 0) begin
      fails++; $display("FAIL ena_valid: got %0d want 0", n_valid-v0);
    end
    if (frame_data !== 16'hBEEF) begin
      fails++; $display("FAIL ena_hold: got %h want beef", frame_data);
    end
    #2 ena = 1'b1;
    settle();
  endtask
`else
  task automatic test_checksum();
    int v0, e0;
    logic [FB-1:0] got, want;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(24'h123446);
    send(8'hAA, 24'h123446, 0, -1, 0, FB);
    repeat (2) @(posedge clk);
    tests += 3;
    if (obs_q.size() == 0) begin
      fails++; $display("FAIL ck_frame: got none want 123446");
      exp_q.delete();
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin
        fails++; $display("FAIL ck_frame: got %h want %h", got, want);
      end
    end
    if (n_err - e0 != 0) begin
      fails++; $display("FAIL ck_err0: got %0d want 0", n_err-e0);
    end
    if (frame_data !== 24'h123446) begin
      fails++; $display("FAIL ck_data: got %h want 123446", frame_data);
    end
    settle();
    v0 = n_valid; e0 = n_err;
    send(8'hAA, 24'h123447, 0, -1, 0, FB);
    repeat (2) @(posedge clk);
    tests += 3;
    if (n_err - e0 != 1) begin
      fails++; $display("FAIL ck_bad_err: got %0d want 1", n_err-e0);
    end
    if (n_valid - v0 != 0) begin
      fails++; $display("FAIL ck_bad_valid: got %0d want 0", n_valid-v0);
    end
    if (frame_data !== 24'h123446) begin
      fails++; $display("FAIL ck_bad_hold: got %h want 123446", frame_data);
    end
    settle();
  endtask
`endif

  initial begin
    test_reset();
`ifdef MANCHESTER_RX_CHECKSUM_EN
    test_checksum();
`else
    test_ideal();
    test_tolerance();
    test_preamble_mismatch();
    test_timeout();
    test_reset_midframe();
    test_ena();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
